// File: rtl/axi3_resp_pkg.sv
// Shared encodings for the AXI3 register-file slave: burst and response
// codes, the controller state enum, the constant returned by word 15 and
// the request-level error decode used for both AW and AR.
`timescale 1ns/1ps
package axi3_resp_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [DATA_W-1:0] REG15_ID = 32'h4158_4933;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        WRESP = 2'd2,
        RDATA = 2'd3
    } state_t;

    // A request is unserviceable when it addresses outside the 16-word
    // window, uses the reserved burst code, or asks for a WRAP whose length
    // is not a power of two.
    function automatic logic req_error(input logic [1:0] addr_hi,
                                       input logic [3:0] len,
                                       input logic [1:0] burst);
        logic wrap_ok;
        wrap_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        return (addr_hi != 2'b00) || (burst == 2'b11) ||
               ((burst == BURST_WRAP) && !wrap_ok);
    endfunction

endpackage

// File: rtl/axi3_burst_addr.sv
// Next word index for an AXI3 burst over a 16-word bank.
//   idx      : current word index
//   len      : burst length minus 1 (sets the WRAP block size)
//   burst    : FIXED / INCR / WRAP
//   next_idx : index of the following beat
`timescale 1ns/1ps
module axi3_burst_addr
    import axi3_resp_pkg::*;
(
    input  logic [3:0] idx,
    input  logic [3:0] len,
    input  logic [1:0] burst,
    output logic [3:0] next_idx
);

    always_comb begin
        next_idx = idx;
        case (burst)
            BURST_INCR: next_idx = idx + 4'd1;
            // len is 2^n-1 for a legal WRAP, so it doubles as the in-block mask.
            BURST_WRAP: next_idx = (idx & ~len) | ((idx + 4'd1) & len);
            default:    next_idx = idx;
        endcase
    end

endmodule

// File: rtl/axi3_regfile_slave.sv
// AXI3 slave exposing a 16 x 32-bit register bank, one transaction at a time.
//   clock, reset      : single clock, synchronous active-high reset
//   s_aw* / s_w* / s_b*: write address, data and response channels
//   s_ar* / s_r*      : read address and data channels
//   add_sel           : reg0[2:0], DDR window select for the address-extension mux
// Word 15 is a read-only identification constant; writes to it are dropped
// but still answered OKAY.
`timescale 1ns/1ps
module axi3_regfile_slave
    import axi3_resp_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        s_awid,
    input  logic [7:0]        s_awaddr,
    input  logic [3:0]        s_awlen,
    input  logic [1:0]        s_awburst,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [3:0]        s_wid,
    input  logic [DATA_W-1:0] s_wdata,
    input  logic [STRB_W-1:0] s_wstrb,
    input  logic              s_wlast,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [3:0]        s_bid,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [3:0]        s_arid,
    input  logic [7:0]        s_araddr,
    input  logic [3:0]        s_arlen,
    input  logic [1:0]        s_arburst,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [3:0]        s_rid,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [2:0]        add_sel
);

    state_t            state_q;
    logic              rdy_q;
    logic              wready_q;
    logic [3:0]        id_q;
    logic [3:0]        idx_q;
    logic [3:0]        len_q;
    logic [1:0]        burst_q;
    logic              err_q;
    logic [3:0]        cnt_q;
    logic              bvalid_q;
    logic [3:0]        bid_q;
    logic [1:0]        bresp_q;
    logic [DATA_W-1:0] rdata_p1;
    logic              vld_p1;
    logic              rlast_p1;
    logic [1:0]        rresp_p1;
    logic [3:0]        rid_p1;
    logic [DATA_W-1:0] bank [16];

    logic [3:0] next_idx;
    logic       wid_bad;
    logic       last_beat;
    logic       beat_err;
    logic       aw_err;
    logic       ar_err;
    logic       unused_addr_lsb;

    axi3_burst_addr u_burst_addr (
        .idx      (idx_q),
        .len      (len_q),
        .burst    (burst_q),
        .next_idx (next_idx)
    );

    function automatic logic [DATA_W-1:0] read_word(input logic [3:0] idx);
        return (idx == 4'hF) ? REG15_ID : bank[idx];
    endfunction

    assign aw_err    = req_error(s_awaddr[7:6], s_awlen, s_awburst);
    assign ar_err    = req_error(s_araddr[7:6], s_arlen, s_arburst);
    assign wid_bad   = (s_wid != id_q);
    assign last_beat = (cnt_q == len_q);
    assign beat_err  = wid_bad | (s_wlast != last_beat);

    // Byte lanes within a word are not addressable.
    assign unused_addr_lsb = ^{s_awaddr[1:0], s_araddr[1:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            rdy_q    <= 1'b0;
            wready_q <= 1'b0;
            id_q     <= '0;
            idx_q    <= '0;
            len_q    <= '0;
            burst_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            bvalid_q <= 1'b0;
            bid_q    <= '0;
            bresp_q  <= RESP_OKAY;
            rdata_p1 <= '0;
            vld_p1   <= 1'b0;
            rlast_p1 <= 1'b0;
            rresp_p1 <= RESP_OKAY;
            rid_p1   <= '0;
            for (int i = 0; i < 16; i++) bank[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rdy_q && s_awvalid) begin
                        id_q     <= s_awid;
                        idx_q    <= s_awaddr[5:2];
                        len_q    <= s_awlen;
                        burst_q  <= s_awburst;
                        err_q    <= aw_err;
                        cnt_q    <= '0;
                        rdy_q    <= 1'b0;
                        wready_q <= 1'b1;
                        state_q  <= WDATA;
                    end else if (rdy_q && s_arvalid) begin
                        idx_q    <= s_araddr[5:2];
                        len_q    <= s_arlen;
                        burst_q  <= s_arburst;
                        err_q    <= ar_err;
                        cnt_q    <= '0;
                        rdy_q    <= 1'b0;
                        // R stage p1: first beat is presented the cycle after AR accept.
                        rdata_p1 <= ar_err ? '0 : read_word(s_araddr[5:2]);
                        vld_p1   <= 1'b1;
                        rlast_p1 <= (s_arlen == 4'd0);
                        rresp_p1 <= ar_err ? RESP_SLVERR : RESP_OKAY;
                        rid_p1   <= s_arid;
                        state_q  <= RDATA;
                    end else begin
                        rdy_q <= 1'b1;
                    end
                end

                WDATA: begin
                    if (s_wvalid && wready_q) begin
                        if (!err_q && !wid_bad && (idx_q != 4'hF)) begin
                            for (int b = 0; b < STRB_W; b++) begin
                                if (s_wstrb[b]) bank[idx_q][8*b +: 8] <= s_wdata[8*b +: 8];
                            end
                        end
                        err_q <= err_q | beat_err;
                        idx_q <= next_idx;
                        cnt_q <= cnt_q + 4'd1;
                        // Beat count, not s_wlast, closes the burst.
                        if (last_beat) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bid_q    <= id_q;
                            bresp_q  <= (err_q | beat_err) ? RESP_SLVERR : RESP_OKAY;
                            state_q  <= WRESP;
                        end
                    end
                end

                WRESP: begin
                    if (s_bready) begin
                        bvalid_q <= 1'b0;
                        rdy_q    <= 1'b1;
                        state_q  <= IDLE;
                    end
                end

                RDATA: begin
                    if (s_rready) begin
                        if (rlast_p1) begin
                            vld_p1   <= 1'b0;
                            rlast_p1 <= 1'b0;
                            rdy_q    <= 1'b1;
                            state_q  <= IDLE;
                        end else begin
                            idx_q    <= next_idx;
                            cnt_q    <= cnt_q + 4'd1;
                            rdata_p1 <= err_q ? '0 : read_word(next_idx);
                            rlast_p1 <= ((cnt_q + 4'd1) == len_q);
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    // AW has priority: AR is held off whenever a write address is offered.
    assign s_awready = rdy_q;
    assign s_arready = rdy_q & ~s_awvalid;
    assign s_wready  = wready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bid     = bid_q;
    assign s_bresp   = bresp_q;
    assign s_rvalid  = vld_p1;
    assign s_rdata   = rdata_p1;
    assign s_rlast   = rlast_p1;
    assign s_rresp   = rresp_p1;
    assign s_rid     = rid_p1;
    assign add_sel   = bank[0][2:0];

endmodule

// File: tb/tb_axi3_regfile_slave.sv
`timescale 1ns/1ps
module tb_axi3_regfile_slave;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  s_awid;
    logic [7:0]  s_awaddr;
    logic [3:0]  s_awlen;
    logic [1:0]  s_awburst;
    logic        s_awvalid;
    logic        s_awready;
    logic [3:0]  s_wid;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wlast;
    logic        s_wvalid;
    logic        s_wready;
    logic [3:0]  s_bid;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [3:0]  s_arid;
    logic [7:0]  s_araddr;
    logic [3:0]  s_arlen;
    logic [1:0]  s_arburst;
    logic        s_arvalid;
    logic        s_arready;
    logic [3:0]  s_rid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        s_rvalid;
    logic        s_rready;
    logic [2:0]  add_sel;

    always #5 clock = ~clock;

    axi3_regfile_slave dut (
        .clock(clock), .reset(reset),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awburst(s_awburst),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arburst(s_arburst),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .add_sel(add_sel)
    );

    int checks = 0;
    int errors = 0;

    // Reference bank contents and per-beat write payload.
    logic [31:0] mem [16];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[15] = 32'h4158_4933;
    endtask

    function automatic bit model_err(input logic [7:0] addr, input int len, input int burst);
        bit wrap_ok;
        wrap_ok = (len == 1) || (len == 3) || (len == 7) || (len == 15);
        return (addr[7:6] != 2'b00) || (burst == 3) || (burst == 2 && !wrap_ok);
    endfunction

    // Word touched by beat b of a burst starting at word 'start'.
    function automatic int model_idx(input int start, input int len, input int burst, input int b);
        int blk;
        int base;
        if (burst == 0) return start;
        if (burst == 1) return (start + b) % 16;
        blk  = len + 1;
        base = start - (start % blk);
        return base + ((start % blk) + b) % blk;
    endfunction

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_awready"}, s_awready, 0);
        chk({tag, "_arready"}, s_arready, 0);
        chk({tag, "_wready"},  s_wready,  0);
        chk({tag, "_bvalid"},  s_bvalid,  0);
        chk({tag, "_bid"},     s_bid,     0);
        chk({tag, "_bresp"},   s_bresp,   0);
        chk({tag, "_rvalid"},  s_rvalid,  0);
        chk({tag, "_rlast"},   s_rlast,   0);
        chk({tag, "_rid"},     s_rid,     0);
        chk({tag, "_rresp"},   s_rresp,   0);
        chk({tag, "_rdata"},   s_rdata,   0);
        chk({tag, "_add_sel"}, add_sel,   0);
    endtask

    // Full write transaction. bad_beat sends that beat with a wrong WID;
    // wlast_flip inverts WLAST on every beat; hold_ar keeps AR valid throughout.
    task automatic do_write(input logic [3:0] id, input logic [7:0] addr, input int len,
                            input int burst, input int bad_beat, input bit wlast_flip,
                            input int b_delay, input bit hold_ar);
        bit err_m;
        int start;
        int idx;
        err_m     = model_err(addr, len, burst);
        start     = int'(addr[5:2]);
        s_awid    = id;
        s_awaddr  = addr;
        s_awlen   = 4'(len);
        s_awburst = 2'(burst);
        s_awvalid = 1'b1;
        if (hold_ar) s_arvalid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            if (s_awready) break;
        end
        chk("aw_ready", s_awready, 1);
        if (hold_ar) chk("ar_blocked_aw", s_arready, 0);
        @(posedge clock); #1;
        s_awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            s_wid    = (b == bad_beat) ? (id ^ 4'h1) : id;
            s_wdata  = wd[b];
            s_wstrb  = ws[b];
            s_wlast  = (b == len) ^ wlast_flip;
            s_wvalid = 1'b1;
            for (int n = 0; n < 100; n++) begin
                @(negedge clock);
                if (s_wready) break;
            end
            chk("w_ready", s_wready, 1);
            if (hold_ar) chk("ar_blocked_w", s_arready, 0);
            idx = model_idx(start, len, burst, b);
            if (!err_m && b != bad_beat && idx != 15) begin
                for (int k = 0; k < 4; k++)
                    if (ws[b][k]) mem[idx][8*k +: 8] = wd[b][8*k +: 8];
            end
            if (b == bad_beat || wlast_flip) err_m = 1'b1;
            @(posedge clock); #1;
        end
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            if (s_bvalid) break;
        end
        chk("b_valid", s_bvalid, 1);
        for (int d = 0; d < b_delay; d++) begin
            @(negedge clock);
            chk("b_hold_valid", s_bvalid, 1);
            chk("b_hold_id", s_bid, id);
        end
        s_bready = 1'b1;
        chk("b_id", s_bid, id);
        chk("b_resp", s_bresp, err_m ? 2'b10 : 2'b00);
        if (hold_ar) chk("ar_blocked_b", s_arready, 0);
        @(posedge clock); #1;
        s_bready = 1'b0;
        chk("b_drop", s_bvalid, 0);
    endtask

    // Full read transaction; every cycle R is valid the presented beat is
    // compared, so holding rready low also checks that R stays stable.
    task automatic do_read(input logic [3:0] id, input logic [7:0] addr, input int len,
                           input int burst, input int stall_at, input bit rand_rdy);
        bit err_m;
        int start;
        int b;
        int stall;
        int idx;
        err_m     = model_err(addr, len, burst);
        start     = int'(addr[5:2]);
        s_arid    = id;
        s_araddr  = addr;
        s_arlen   = 4'(len);
        s_arburst = 2'(burst);
        s_arvalid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            if (s_arready) break;
        end
        chk("ar_ready", s_arready, 1);
        @(posedge clock); #1;
        s_arvalid = 1'b0;
        s_rready  = rand_rdy ? 1'($urandom % 2) : 1'b1;
        b     = 0;
        stall = 0;
        for (int cyc = 0; cyc < 400 && b <= len; cyc++) begin
            @(negedge clock);
            if (cyc == 0) chk("r_first_valid", s_rvalid, 1);
            if (s_rvalid) begin
                idx = model_idx(start, len, burst, b);
                chk("r_data", s_rdata, err_m ? 32'h0 : mem[idx]);
                chk("r_last", s_rlast, b == len);
                if (s_rready) begin
                    chk("r_resp", s_rresp, err_m ? 2'b10 : 2'b00);
                    chk("r_id", s_rid, id);
                    b++;
                end
            end
            @(posedge clock); #1;
            if (b == stall_at && stall < 5) begin
                s_rready = 1'b0;
                stall++;
            end else begin
                s_rready = rand_rdy ? 1'($urandom % 2) : 1'b1;
            end
        end
        chk("r_beats", b, len + 1);
        s_rready = 1'b0;
    endtask

    initial begin
        logic [7:0] ra;
        int rlen;
        int rburst;
        int bad;

        reset = 1'b1;
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awburst = '0; s_awvalid = 1'b0;
        s_wid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0;
        s_bready = 1'b0;
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arburst = '0; s_arvalid = 1'b0;
        s_rready = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_outputs_zero("rst");
        reset = 1'b0;

        // Single-beat write of 6 to word 0 drives add_sel.
        wd[0] = 32'h6; ws[0] = 4'hF;
        do_write(4'd5, 8'h00, 0, 1, -1, 1'b0, 0, 1'b0);
        chk("add_sel_6", add_sel, 3'b110);

        // INCR across the top of the bank; word 15 keeps its ID.
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(4'd2, 8'h38, 3, 1, -1, 1'b0, 2, 1'b0);
        do_read(4'd2, 8'h38, 3, 1, -1, 1'b0);
        do_read(4'd1, 8'h3C, 0, 0, -1, 1'b0);

        // WRAP len 3 from word 2 -> 2,3,0,1; read back linearly and as WRAP.
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(4'd3, 8'h08, 3, 2, -1, 1'b0, 0, 1'b0);
        do_read(4'd3, 8'h00, 3, 1, -1, 1'b0);
        do_read(4'd3, 8'h08, 3, 2, -1, 1'b0);

        // Illegal WRAP length: SLVERR, no bank change, reads return 0/SLVERR.
        for (int i = 0; i < 3; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(4'd4, 8'h10, 2, 2, -1, 1'b0, 0, 1'b0);
        do_read(4'd4, 8'h10, 3, 1, -1, 1'b0);
        do_read(4'd4, 8'h10, 2, 2, -1, 1'b0);

        // WLAST mismatch (aimed at read-only word 15) and out-of-window address.
        wd[0] = $urandom; ws[0] = 4'hF;
        do_write(4'd6, 8'h3C, 0, 1, -1, 1'b1, 0, 1'b0);
        do_write(4'd7, 8'h44, 0, 1, -1, 1'b0, 0, 1'b0);

        // AW and AR offered together: write first, AR held off until B done.
        s_arid = 4'd9; s_araddr = 8'h04; s_arlen = 4'd0; s_arburst = 2'b01;
        wd[0] = $urandom; ws[0] = 4'hF;
        do_write(4'd8, 8'h04, 0, 1, -1, 1'b0, 1, 1'b1);
        do_read(4'd9, 8'h04, 0, 1, -1, 1'b0);

        // R back-pressure for 5 cycles in the middle of a burst.
        do_read(4'd10, 8'h00, 3, 1, 2, 1'b0);

        // Randomized traffic against the reference bank.
        for (int t = 0; t < 40; t++) begin
            ra = 8'($urandom);
            if ($urandom % 6 != 0) ra[7:6] = 2'b00;
            rburst = $urandom % 4;
            rlen   = $urandom % 16;
            if (rburst == 2 && ($urandom % 2) == 1) rlen = (2 << ($urandom % 4)) - 1;
            if ($urandom % 2 == 0) begin
                for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
                bad = ($urandom % 6 == 0) ? int'($urandom_range(0, rlen)) : -1;
                do_write(4'($urandom), ra, rlen, rburst, bad, 1'b0, $urandom % 3, 1'b0);
            end else begin
                do_read(4'($urandom), ra, rlen, rburst, -1, 1'b1);
            end
        end
        chk("add_sel_final", add_sel, mem[0][2:0]);

        // Reset in the middle of a write burst: everything clears, no response.
        wd[0] = $urandom;
        s_awid = 4'd1; s_awaddr = 8'h00; s_awlen = 4'd3; s_awburst = 2'b01; s_awvalid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            if (s_awready) break;
        end
        chk("mid_aw_ready", s_awready, 1);
        @(posedge clock); #1;
        s_awvalid = 1'b0;
        s_wid = 4'd1; s_wdata = wd[0]; s_wstrb = 4'hF; s_wlast = 1'b0; s_wvalid = 1'b1;
        @(posedge clock); #1;
        s_wvalid = 1'b0;
        chk("mid_wready", s_wready, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        check_outputs_zero("mid_rst");
        reset = 1'b0;
        model_reset();
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            chk("mid_no_b", s_bvalid, 0);
        end
        @(posedge clock); #1;
        do_read(4'd0, 8'h00, 15, 1, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
